// File: rtl/game_ctrl_pkg.sv
// Shared types and helpers for the game flow controller.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    FLASH     = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int unsigned LIVES_W = 3;

  // Vectors up to 32 bits wide; callers zero-extend narrower shot vectors.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky-OR collision accumulator; releases one snapshot pulse the cycle after startOfFrame.
module frame_event_latch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic [WIDTH-1:0] event_in,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] acc;

  // A collision coinciding with startOfFrame seeds the new frame's accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      pulse <= '0;
    end else if (startOfFrame) begin
      pulse <= acc;
      acc   <= event_in;
    end else begin
      pulse <= '0;
      acc   <= acc | event_in;
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Turns per-pixel collision levels into per-frame events and runs score, lives and play/flash/game-over flow.
module game_state_controller
  import game_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SHOTS     = 3,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned SCORE_W       = 10,
  parameter int unsigned SCORE_PER_HIT = 1,
  parameter int unsigned FLASH_FRAMES  = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 start_key,
  input  logic [NUM_SHOTS-1:0] ShotEnemyCollision,
  input  logic [NUM_SHOTS-1:0] ShotBoxCollision,
  input  logic                 TowerEnemyHUCollision,
  output logic [NUM_SHOTS-1:0] shot_kill_pulse,
  output logic [NUM_SHOTS-1:0] shot_absorb_pulse,
  output logic                 enemy_hit_pulse,
  output logic                 tower_hit_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic [1:0]           game_state,
  output logic                 game_active,
  output logic                 flash
);

  localparam int unsigned SUM_W   = SCORE_W + 4;
  localparam int unsigned FLASH_W = 8;

  logic [NUM_SHOTS-1:0] kill_snap;
  logic [NUM_SHOTS-1:0] absorb_snap;
  logic                 tower_snap;

  game_state_t          state, state_nxt;
  logic [SCORE_W-1:0]   score_nxt;
  logic [LIVES_W-1:0]   lives_nxt;
  logic [FLASH_W-1:0]   flash_cnt, flash_cnt_nxt;
  logic                 start_q;
  logic                 start_rise;
  logic                 closed_in_play;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_add;

  frame_event_latch #(.WIDTH(NUM_SHOTS)) u_kill_latch (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .event_in     (ShotEnemyCollision),
    .pulse        (kill_snap)
  );

  frame_event_latch #(.WIDTH(NUM_SHOTS)) u_absorb_latch (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .event_in     (ShotBoxCollision),
    .pulse        (absorb_snap)
  );

  frame_event_latch #(.WIDTH(1)) u_tower_latch (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .event_in     (TowerEnemyHUCollision),
    .pulse        (tower_snap)
  );

  assign start_rise  = start_key & ~start_q;
  assign game_active = (state == PLAY) || (state == FLASH);
  assign flash       = (state == FLASH);
  assign game_state  = state;

  assign shot_kill_pulse   = game_active ? kill_snap   : '0;
  assign shot_absorb_pulse = game_active ? absorb_snap : '0;
  assign enemy_hit_pulse   = |shot_kill_pulse;
  // A frame that closed while invulnerable cannot cost a life, even if PLAY resumed at that boundary.
  assign tower_hit_pulse   = (state == PLAY) && closed_in_play && tower_snap;

  assign score_sum = {4'b0000, score}
                   + SUM_W'(popcount(32'(shot_kill_pulse)) * SCORE_PER_HIT);
  assign score_add = (score_sum > {4'b0000, {SCORE_W{1'b1}}}) ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    state_nxt     = state;
    score_nxt     = score;
    lives_nxt     = lives;
    flash_cnt_nxt = flash_cnt;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = PLAY;
          score_nxt = '0;
          lives_nxt = LIVES_W'(LIVES_INIT);
        end
      end
      PLAY: begin
        score_nxt = score_add;
        if (tower_hit_pulse) begin
          if (lives > LIVES_W'(1)) begin
            state_nxt     = FLASH;
            lives_nxt     = lives - LIVES_W'(1);
            flash_cnt_nxt = FLASH_W'(FLASH_FRAMES);
          end else begin
            state_nxt = GAME_OVER;
            lives_nxt = '0;
          end
        end
      end
      FLASH: begin
        score_nxt = score_add;
        if (startOfFrame) begin
          if (flash_cnt == FLASH_W'(1)) begin
            state_nxt     = PLAY;
            flash_cnt_nxt = '0;
          end else begin
            flash_cnt_nxt = flash_cnt - FLASH_W'(1);
          end
        end
      end
      GAME_OVER: begin
        if (start_rise) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      score          <= '0;
      lives          <= LIVES_W'(LIVES_INIT);
      flash_cnt      <= '0;
      start_q        <= 1'b0;
      closed_in_play <= 1'b0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      flash_cnt <= flash_cnt_nxt;
      start_q   <= start_key;
      if (startOfFrame) begin
        closed_in_play <= (state == PLAY);
      end
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with a frame-level reference model checked every cycle.
module tb_game_state_controller;

  localparam int NS   = 3;
  localparam int LI   = 3;
  localparam int SW   = 10;
  localparam int SPH  = 1;
  localparam int FF   = 30;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sof = 1'b0;
  logic          start_key = 1'b0;
  logic [NS-1:0] sec = '0;
  logic [NS-1:0] sbc = '0;
  logic          tec = 1'b0;

  logic [NS-1:0] kill_p, absorb_p;
  logic          enemy_p, tower_p;
  logic [SW-1:0] score;
  logic [2:0]    lives;
  logic [1:0]    gstate;
  logic          active, flash;

  always #5 clk = ~clk;

  game_state_controller #(
    .NUM_SHOTS(NS), .LIVES_INIT(LI), .SCORE_W(SW), .SCORE_PER_HIT(SPH), .FLASH_FRAMES(FF)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .startOfFrame          (sof),
    .start_key             (start_key),
    .ShotEnemyCollision    (sec),
    .ShotBoxCollision      (sbc),
    .TowerEnemyHUCollision (tec),
    .shot_kill_pulse       (kill_p),
    .shot_absorb_pulse     (absorb_p),
    .enemy_hit_pulse       (enemy_p),
    .tower_hit_pulse       (tower_p),
    .score                 (score),
    .lives                 (lives),
    .game_state            (gstate),
    .game_active           (active),
    .flash                 (flash)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase 0=idle 1=play 2=flash 3=over, per-frame collision sets.
  int        m_state, m_score, m_lives, m_flash_left;
  bit [NS-1:0] fr_kill, fr_abs, sn_kill, sn_abs;
  bit        fr_tow, sn_tow, closed_play, prev_start, model_ok;

  function automatic bit [NS-1:0] m_kill();
    return (m_state == 1 || m_state == 2) ? sn_kill : '0;
  endfunction
  function automatic bit [NS-1:0] m_abs();
    return (m_state == 1 || m_state == 2) ? sn_abs : '0;
  endfunction
  function automatic bit m_tow();
    return (m_state == 1) && closed_play && sn_tow;
  endfunction

  always @(posedge clk) begin
    int old_state;
    bit rise;
    bit [NS-1:0] cur_kill;
    bit cur_tow;
    if (reset) begin
      m_state = 0; m_score = 0; m_lives = LI; m_flash_left = 0;
      fr_kill = '0; fr_abs = '0; fr_tow = 0;
      sn_kill = '0; sn_abs = '0; sn_tow = 0;
      closed_play = 0; prev_start = 0; model_ok = 1;
    end else begin
      old_state  = m_state;
      rise       = start_key && !prev_start;
      prev_start = start_key;
      cur_kill   = m_kill();
      cur_tow    = m_tow();
      if (m_state == 0 && rise) begin
        m_state = 1; m_score = 0; m_lives = LI;
      end else if (m_state == 3 && rise) begin
        m_state = 0;
      end else begin
        m_score = m_score + $countones(cur_kill) * SPH;
        if (m_score > SMAX) m_score = SMAX;
        if (cur_tow) begin
          if (m_lives > 1) begin
            m_lives--; m_state = 2; m_flash_left = FF;
          end else begin
            m_lives = 0; m_state = 3;
          end
        end else if (m_state == 2 && sof) begin
          m_flash_left--;
          if (m_flash_left == 0) m_state = 1;
        end
      end
      if (sof) begin
        sn_kill = fr_kill; sn_abs = fr_abs; sn_tow = fr_tow;
        closed_play = (old_state == 1);
        fr_kill = sec; fr_abs = sbc; fr_tow = tec;
      end else begin
        sn_kill = '0; sn_abs = '0; sn_tow = 0;
        fr_kill |= sec; fr_abs |= sbc; fr_tow |= tec;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !reset) begin
      check("m_kill",   32'(kill_p),   32'(m_kill()));
      check("m_absorb", 32'(absorb_p), 32'(m_abs()));
      check("m_enemy",  32'(enemy_p),  32'(|m_kill()));
      check("m_tower",  32'(tower_p),  32'(m_tow()));
      check("m_score",  32'(score),    m_score);
      check("m_lives",  32'(lives),    m_lives);
      check("m_state",  32'(gstate),   m_state);
      check("m_active", 32'(active),   32'(m_state == 1 || m_state == 2));
      check("m_flash",  32'(flash),    32'(m_state == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic fill(input logic [NS-1:0] k, input logic [NS-1:0] a, input logic t, input int len);
    sec = k; sbc = a; tec = t;
    repeat (len) tick();
    sec = '0; sbc = '0; tec = 1'b0;
  endtask

  task automatic wait_flash_out();
    for (int i = 1; i <= FF; i++) begin
      sof_tick();
      fill('0, '0, 1'b0, 4);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_state", 32'(gstate), 0);
    check("rst_score", 32'(score), 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_kill", 32'(kill_p), 0);
    check("rst_tower", 32'(tower_p), 0);
    reset = 1'b0;
    repeat (2) tick();

    start_key = 1'b1; tick();
    check("start_state", 32'(gstate), 1);
    check("start_score", 32'(score), 0);
    check("start_lives", 32'(lives), 3);
    start_key = 1'b0; tick();

    // one event per frame from a 20-cycle collision
    sof_tick();
    fill(3'b101, 3'b010, 1'b0, 20);
    sof_tick();
    check("kill_101", 32'(kill_p), 5);
    check("enemy_hit", 32'(enemy_p), 1);
    check("absorb_010", 32'(absorb_p), 2);
    check("score_pre", 32'(score), 0);
    tick();
    check("kill_one_cycle", 32'(kill_p), 0);
    check("score_2", 32'(score), 2);
    fill('0, '0, 1'b0, 6);
    sof_tick();
    check("kill_quiet", 32'(kill_p), 0);

    // collision on the startOfFrame cycle belongs to the new frame
    sof = 1'b1; sec = 3'b010; tick(); sof = 1'b0; sec = '0;
    check("sof_same_cycle", 32'(kill_p), 0);
    fill('0, '0, 1'b0, 5);
    sof_tick();
    check("deferred_kill", 32'(kill_p), 2);
    tick();
    check("score_3", 32'(score), 3);

    // tower hit with 3 lives, then invulnerability
    fill('0, '0, 1'b1, 3);
    sof_tick();
    check("tower_pulse", 32'(tower_p), 1);
    tick();
    check("lives_2", 32'(lives), 2);
    check("state_flash", 32'(gstate), 2);
    check("flash_on", 32'(flash), 1);
    for (int i = 1; i <= FF; i++) begin
      sof_tick();
      if (i == 6) begin
        check("flash_no_tower", 32'(tower_p), 0);
        check("flash_lives", 32'(lives), 2);
      end
      if (i == FF - 1) check("flash_29", 32'(gstate), 2);
      if (i == FF) check("flash_exit", 32'(gstate), 1);
      fill('0, '0, (i == 5), 4);
    end

    // down to last life, then game over
    fill('0, '0, 1'b1, 3);
    sof_tick();
    tick();
    check("lives_1", 32'(lives), 1);
    wait_flash_out();
    check("play_again", 32'(gstate), 1);
    fill('0, '0, 1'b1, 3);
    sof_tick();
    check("last_tower", 32'(tower_p), 1);
    tick();
    check("lives_0", 32'(lives), 0);
    check("game_over", 32'(gstate), 3);
    check("over_inactive", 32'(active), 0);
    fill(3'b111, 3'b111, 1'b1, 4);
    sof_tick();
    check("over_no_kill", 32'(kill_p), 0);
    check("over_no_tower", 32'(tower_p), 0);
    tick();
    check("over_score", 32'(score), 3);
    start_key = 1'b1; tick();
    check("over_to_idle", 32'(gstate), 0);
    start_key = 1'b0; tick();
    check("idle_score_held", 32'(score), 3);
    start_key = 1'b1; tick();
    check("restart_state", 32'(gstate), 1);
    check("restart_score", 32'(score), 0);
    check("restart_lives", 32'(lives), 3);
    start_key = 1'b0; tick();

    // kill and tower hit in the same frame
    fill('0, '0, 1'b1, 3);
    sof_tick();
    tick();
    check("lives_2b", 32'(lives), 2);
    wait_flash_out();
    fill(3'b011, '0, 1'b1, 3);
    sof_tick();
    check("combo_kill", 32'(kill_p), 3);
    check("combo_tower", 32'(tower_p), 1);
    tick();
    check("combo_score", 32'(score), 2);
    check("combo_lives", 32'(lives), 1);
    check("combo_flash", 32'(gstate), 2);
    wait_flash_out();

    // drive score to saturation
    for (int i = 0; i < 340; i++) begin
      fill(3'b111, '0, 1'b0, 2);
      sof_tick();
    end
    tick();
    check("score_1022", 32'(score), 1022);
    fill(3'b111, '0, 1'b0, 2);
    sof_tick();
    tick();
    check("score_sat", 32'(score), 1023);
    fill(3'b111, '0, 1'b0, 2);
    sof_tick();
    tick();
    check("score_sat_hold", 32'(score), 1023);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
